// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: MEM-stage load/store bus controller.
// Accepts one load/store from EX, runs it as a single req/ack bus transaction
// while stalling the pipeline, then returns aligned and extended load data.
// Optional feature macro: LSU_ALIGN_CHECK_EN (misaligned half/word accesses
// fault instead of being silently aligned down).
module lsu_bus_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        exn,
    input  logic        req_valid,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [1:0]  mem_sz,
    input  logic        mem_sx,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic [4:0]  ld_rd,
    output logic        misalign
);

`ifdef LSU_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg;
    logic [1:0]  sz_reg;         // normalised: 0 byte, 1 half, 2 word
    logic        sx_reg;
    logic        we_reg;
    logic [31:0] wdata_reg;
    logic [4:0]  rd_reg;
    logic        drop_reg;       // flushed while the bus cycle was in flight
    logic        mis_reg;        // accepted access was misaligned (check mode)
    logic [31:0] ld_data_reg;
    logic [4:0]  ld_rd_reg;

    logic        accept;
    logic        in_half, in_word, misaligned_in;
    logic [1:0]  sz_in;
    logic [31:0] aligned_addr;
    logic [3:0]  be;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_data;

    // Request decode and alignment of the incoming EX access.
    always_comb begin
        accept        = req_valid & (mem_r | mem_w) & ~exn;
        in_word       = mem_sz[1];
        in_half       = (mem_sz == 2'd1);
        sz_in         = in_word ? 2'd2 : mem_sz;
        misaligned_in = (in_half & addr[0]) | (in_word & (addr[1:0] != 2'b00));
        // Low bits below the access size are cleared so the bus never sees a
        // lane-straddling access.
        aligned_addr  = {addr[31:2], addr[1] & ~in_word, addr[0] & ~(in_word | in_half)};
    end

    // Byte enable per lane from the captured offset and size.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_be
            assign be[gi] = (sz_reg == 2'd2)
                          | ((sz_reg == 2'd1) & (addr_reg[1] == gi[1]))
                          | ((sz_reg == 2'd0) & (addr_reg[1:0] == gi[1:0]));
        end
    endgenerate

    // Lane extraction and zero/sign extension of read data.
    always_comb begin
        byte_sel = 8'(bus_rdata >> {addr_reg[1:0], 3'b000});
        half_sel = addr_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (sz_reg)
            2'd0:    ext_data = {{24{sx_reg & byte_sel[7]}}, byte_sel};
            2'd1:    ext_data = {{16{sx_reg & half_sel[15]}}, half_sel};
            default: ext_data = bus_rdata;
        endcase
    end

    // Next-state and output decode.
    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = 32'd0;
        bus_be     = 4'd0;
        bus_wdata  = 32'd0;
        ld_valid   = 1'b0;
        misalign   = 1'b0;
        case (state_reg)
            IDLE: begin
                stall = accept;
                if (accept)
                    state_next = (ALIGN_CHECK && misaligned_in) ? DONE : BUSY;
            end
            BUSY: begin
                stall     = 1'b1;
                bus_req   = 1'b1;
                bus_we    = we_reg;
                bus_addr  = {addr_reg[31:2], 2'b00};
                bus_be    = be;
                bus_wdata = wdata_reg;
                if (bus_ack)
                    state_next = (drop_reg | exn) ? IDLE : DONE;
            end
            DONE: begin
                ld_valid   = ~we_reg & ~mis_reg & ~exn;
                misalign   = mis_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, request capture and load result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            addr_reg    <= 32'd0;
            sz_reg      <= 2'd0;
            sx_reg      <= 1'b0;
            we_reg      <= 1'b0;
            wdata_reg   <= 32'd0;
            rd_reg      <= 5'd0;
            drop_reg    <= 1'b0;
            mis_reg     <= 1'b0;
            ld_data_reg <= 32'd0;
            ld_rd_reg   <= 5'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && accept) begin
                addr_reg  <= aligned_addr;
                sz_reg    <= sz_in;
                sx_reg    <= mem_sx;
                we_reg    <= mem_w;
                wdata_reg <= wdata;
                rd_reg    <= rd;
                drop_reg  <= 1'b0;
                mis_reg   <= ALIGN_CHECK & misaligned_in;
            end
            if (state_reg == BUSY && exn)
                drop_reg <= 1'b1;
            // Load result only updates for a load that will be delivered,
            // so it holds its last valid value otherwise.
            if (state_reg == BUSY && bus_ack && !we_reg && !drop_reg && !exn) begin
                ld_data_reg <= ext_data;
                ld_rd_reg   <= rd_reg;
            end
        end
    end

    assign ld_data = ld_data_reg;
    assign ld_rd   = ld_rd_reg;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Testbench for lsu_bus_ctrl: directed scenarios plus randomized accesses
// checked against a byte-lane reference model.
module tb_lsu_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst, exn, req_valid, mem_r, mem_w, mem_sx;
    logic [1:0]  mem_sz;
    logic [31:0] addr, wdata, bus_rdata;
    logic [4:0]  rd;
    logic        bus_ack;
    logic        bus_req, bus_we, stall, ld_valid, misalign;
    logic [31:0] bus_addr, bus_wdata, ld_data;
    logic [3:0]  bus_be;
    logic [4:0]  ld_rd;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations of the most recent access, used by the directed tests.
    int          last_stall_cnt, last_req_cnt;
    logic [31:0] last_addr, last_ld_data;
    logic [3:0]  last_be;
    logic        last_we;

    lsu_bus_ctrl dut (
        .clk(clk), .rst(rst), .exn(exn), .req_valid(req_valid),
        .mem_r(mem_r), .mem_w(mem_w), .mem_sz(mem_sz), .mem_sx(mem_sx),
        .addr(addr), .wdata(wdata), .rd(rd),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .stall(stall), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_rd(ld_rd), .misalign(misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full access. waits = extra BUSY cycles before ack; exn_at = BUSY
    // cycle index at which exn pulses (waits+1 means the DONE cycle, -1 none).
    task automatic run_access(input logic we, input logic [1:0] sz, input logic sx,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [4:0] r, input logic [31:0] rdat,
                              input int waits, input int exn_at, input string tag);
        int          nbytes, off;
        logic [31:0] ea, exp_addr, exp_data, mask;
        logic [3:0]  exp_be;
        logic        mis, dropped, exp_lv;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        mis    = (a % nbytes) != 0;
`ifdef LSU_ALIGN_CHECK_EN
        ea = a;
`else
        ea = a - (a % nbytes);
`endif
        exp_addr = ea - (ea % 4);
        off      = int'(ea % 4);
        exp_be   = 4'(((1 << nbytes) - 1) << off);
        mask     = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 1);
        exp_data = (rdat >> (8 * off)) & mask;
        if (sx && nbytes < 4 && exp_data[8 * nbytes - 1]) exp_data = exp_data | ~mask;

        last_stall_cnt = 0;
        last_req_cnt   = 0;
        req_valid = 1'b1; mem_r = ~we; mem_w = we; mem_sz = sz; mem_sx = sx;
        addr = a; wdata = wd; rd = r;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL %s accept_stall got %b want 1", tag, stall); end
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL %s accept_bus_req got %b want 0", tag, bus_req); end
        last_stall_cnt++;
        tick();

`ifdef LSU_ALIGN_CHECK_EN
        if (mis) begin
            n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL %s mis_bus_req got %b want 0", tag, bus_req); end
            n_checks++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL %s misalign got %b want 1", tag, misalign); end
            n_checks++; if (ld_valid !== 1'b0) begin n_fail++; $display("FAIL %s mis_ld_valid got %b want 0", tag, ld_valid); end
            n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL %s mis_stall got %b want 0", tag, stall); end
            req_valid = 1'b0;
            tick();
            n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL %s misalign_pulse got %b want 0", tag, misalign); end
            $display("txn %s: misaligned addr=%h sz=%0d", tag, a, sz);
            return;
        end
`endif

        dropped = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL %s bus_req c%0d got %b want 1", tag, i, bus_req); end
            n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL %s busy_stall c%0d got %b want 1", tag, i, stall); end
            n_checks++; if (bus_we !== we) begin n_fail++; $display("FAIL %s bus_we got %b want %b", tag, bus_we, we); end
            n_checks++; if (bus_addr !== exp_addr) begin n_fail++; $display("FAIL %s bus_addr got %h want %h", tag, bus_addr, exp_addr); end
            n_checks++; if (bus_be !== exp_be) begin n_fail++; $display("FAIL %s bus_be got %b want %b", tag, bus_be, exp_be); end
            if (we) begin
                n_checks++; if (bus_wdata !== wd) begin n_fail++; $display("FAIL %s bus_wdata got %h want %h", tag, bus_wdata, wd); end
            end
            if (i == 0) begin
                last_addr = bus_addr; last_be = bus_be; last_we = bus_we;
            end
            if (bus_req === 1'b1) last_req_cnt++;
            if (stall === 1'b1) last_stall_cnt++;
            if (i == exn_at) begin
                exn = 1'b1; req_valid = 1'b0; dropped = 1'b1;
            end
            bus_ack   = (i == waits);
            bus_rdata = (i == waits) ? rdat : $urandom;
            tick();
            exn = 1'b0; bus_ack = 1'b0;
        end

        if (dropped) begin
            n_checks++; if (ld_valid !== 1'b0) begin n_fail++; $display("FAIL %s drop_ld_valid got %b want 0", tag, ld_valid); end
            n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL %s drop_bus_req got %b want 0", tag, bus_req); end
            n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL %s drop_stall got %b want 0", tag, stall); end
            $display("txn %s: dropped we=%b addr=%h", tag, we, a);
            return;
        end

        exp_lv = ~we;
        if (exn_at == waits + 1) begin
            exn = 1'b1; exp_lv = 1'b0;
            #1;
        end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL %s done_stall got %b want 0", tag, stall); end
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL %s done_bus_req got %b want 0", tag, bus_req); end
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL %s misalign got %b want 0", tag, misalign); end
        n_checks++; if (ld_valid !== exp_lv) begin n_fail++; $display("FAIL %s ld_valid got %b want %b", tag, ld_valid, exp_lv); end
        if (exp_lv) begin
            n_checks++; if (ld_data !== exp_data) begin n_fail++; $display("FAIL %s ld_data got %h want %h", tag, ld_data, exp_data); end
            n_checks++; if (ld_rd !== r) begin n_fail++; $display("FAIL %s ld_rd got %0d want %0d", tag, ld_rd, r); end
        end
        last_ld_data = ld_data;
        req_valid = 1'b0;
        tick();
        exn = 1'b0;
        n_checks++; if (ld_valid !== 1'b0) begin n_fail++; $display("FAIL %s idle_ld_valid got %b want 0", tag, ld_valid); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL %s idle_stall got %b want 0", tag, stall); end
        if (exp_lv) begin
            n_checks++; if (ld_data !== exp_data) begin n_fail++; $display("FAIL %s ld_data_hold got %h want %h", tag, ld_data, exp_data); end
        end
        $display("txn %s: we=%b sz=%0d sx=%b addr=%h rdata=%h waits=%0d exn_at=%0d ld=%h",
                 tag, we, sz, sx, a, rdat, waits, exn_at, last_ld_data);
    endtask

    task automatic test_reset();
        logic [109:0] outs;
        rst = 1'b1;
        tick(); tick();
        outs = {bus_req, bus_we, bus_addr, bus_be, bus_wdata, stall, ld_valid, ld_data, ld_rd, misalign};
        n_checks++; if (outs !== 110'd0) begin n_fail++; $display("FAIL reset_outputs got %h want 0", outs); end
        rst = 1'b0;
        tick();
        $display("txn reset: outputs %h", outs);
    endtask

    task automatic test_byte_load_sx();
        run_access(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 5'd7, 32'h80FF_FFFF, 0, -1, "byte_ld_sx");
        n_checks++; if (last_addr !== 32'h1000) begin n_fail++; $display("FAIL byte_ld_sx addr got %h want 00001000", last_addr); end
        n_checks++; if (last_be !== 4'b1000) begin n_fail++; $display("FAIL byte_ld_sx be got %b want 1000", last_be); end
        n_checks++; if (last_ld_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL byte_ld_sx data got %h want ffffff80", last_ld_data); end
        n_checks++; if (last_stall_cnt !== 2) begin n_fail++; $display("FAIL byte_ld_sx stall_cycles got %0d want 2", last_stall_cnt); end
    endtask

    task automatic test_half_store_wait();
        run_access(1'b1, 2'd1, 1'b0, 32'h2002, 32'hBEEF_BEEF, 5'd3, 32'h0, 2, -1, "half_st_wait");
        n_checks++; if (last_req_cnt !== 3) begin n_fail++; $display("FAIL half_st_wait req_cycles got %0d want 3", last_req_cnt); end
        n_checks++; if (last_stall_cnt !== 4) begin n_fail++; $display("FAIL half_st_wait stall_cycles got %0d want 4", last_stall_cnt); end
        n_checks++; if (last_be !== 4'b1100) begin n_fail++; $display("FAIL half_st_wait be got %b want 1100", last_be); end
        n_checks++; if (last_we !== 1'b1) begin n_fail++; $display("FAIL half_st_wait we got %b want 1", last_we); end
    endtask

    task automatic test_half_load_zx();
        run_access(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 5'd12, 32'h1234_ABCD, 1, -1, "half_ld_zx");
        n_checks++; if (last_ld_data !== 32'h0000_ABCD) begin n_fail++; $display("FAIL half_ld_zx data got %h want 0000abcd", last_ld_data); end
    endtask

    task automatic test_flush_busy();
        run_access(1'b0, 2'd2, 1'b0, 32'h3000, 32'h0, 5'd9, 32'hCAFE_F00D, 2, 0, "flush_busy");
        n_checks++; if (last_req_cnt !== 3) begin n_fail++; $display("FAIL flush_busy req_cycles got %0d want 3", last_req_cnt); end
    endtask

    task automatic test_flush_idle_done();
        req_valid = 1'b1; mem_r = 1'b1; mem_w = 1'b0; mem_sz = 2'd2; addr = 32'h40; exn = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_idle stall got %b want 0", stall); end
        tick();
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL flush_idle bus_req got %b want 0", bus_req); end
        exn = 1'b0; req_valid = 1'b0;
        tick();
        $display("txn flush_idle: nothing accepted");
        run_access(1'b0, 2'd0, 1'b0, 32'h41, 32'h0, 5'd4, 32'h0000_5500, 0, 1, "flush_done");
    endtask

    task automatic test_misalign();
        run_access(1'b0, 2'd2, 1'b0, 32'h4001, 32'h0, 5'd5, 32'h1122_3344, 0, -1, "mis_word");
`ifdef LSU_ALIGN_CHECK_EN
        n_checks++; if (last_req_cnt !== 0) begin n_fail++; $display("FAIL mis_word req_cycles got %0d want 0", last_req_cnt); end
`else
        n_checks++; if (last_addr !== 32'h4000) begin n_fail++; $display("FAIL mis_word addr got %h want 00004000", last_addr); end
        n_checks++; if (last_be !== 4'b1111) begin n_fail++; $display("FAIL mis_word be got %b want 1111", last_be); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [109:0] outs;
        req_valid = 1'b1; mem_r = 1'b1; mem_w = 1'b0; mem_sz = 2'd2; addr = 32'h5000; rd = 5'd2;
        tick();
        n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL reset_mid busy got %b want 1", bus_req); end
        rst = 1'b1; req_valid = 1'b0;
        tick();
        rst = 1'b0;
        outs = {bus_req, bus_we, bus_addr, bus_be, bus_wdata, stall, ld_valid, ld_data, ld_rd, misalign};
        n_checks++; if (outs !== 110'd0) begin n_fail++; $display("FAIL reset_mid outputs got %h want 0", outs); end
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        tick();
        bus_ack = 1'b0;
        n_checks++; if ({ld_valid, bus_req, stall} !== 3'b000) begin n_fail++; $display("FAIL reset_mid stray_ack got %b want 000", {ld_valid, bus_req, stall}); end
        $display("txn reset_mid: outputs %h", outs);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic        we;
            int          w, e;
            we = 1'($urandom_range(0, 1));
            w  = int'($urandom_range(0, 3));
            e  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, w + 1)) : -1;
            run_access(we, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                       $urandom, 5'($urandom), $urandom, w, e, $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        rst = 1'b1; exn = 1'b0; req_valid = 1'b0; mem_r = 1'b0; mem_w = 1'b0;
        mem_sz = 2'd0; mem_sx = 1'b0; addr = 32'd0; wdata = 32'd0; rd = 5'd0;
        bus_ack = 1'b0; bus_rdata = 32'd0;
        test_reset();
        test_byte_load_sx();
        test_half_store_wait();
        test_half_load_zx();
        test_flush_busy();
        test_flush_idle_done();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
